mod_updown_counter: RTL and testbench



---
 rtl/cnt_pkg.sv | 17 +
 rtl/mod_step.sv | 51 +++++
 rtl/mod_updown_counter.sv | 89 ++++++++
 tb/tb_mod_updown_counter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the mod_updown_counter slice.
package cnt_pkg;

    localparam logic CNT_DN = 1'b0;
    localparam logic CNT_UP = 1'b1;

    // Smallest bit width able to hold every value 0..modulus-1.
    function automatic int unsigned min_width(input int unsigned modulus);
        int unsigned w;
        w = 1;
        while ((64'(1) << w) < 64'(modulus)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mod_step.sv
// Combinational next-count for a modulo up/down counter, wrapping or saturating
// at the range limits; arithmetic is done one bit wider than the count.
module mod_step #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_up_dn,
    output logic [WIDTH-1:0] o_next_q,
    output logic             o_is_limit
);
    import cnt_pkg::*;

    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] w_q_ext;
    logic [WIDTH:0] w_next_ext;
    logic           w_at_top;
    logic           w_at_bot;
    logic           w_unused_carry;

    assign w_q_ext  = {1'b0, i_q};
    assign w_at_top = (w_q_ext == MAX_EXT);
    assign w_at_bot = (w_q_ext == '0);

    always_comb begin
        w_next_ext = w_q_ext;
        o_is_limit = 1'b0;
        if (i_up_dn == CNT_UP) begin
            o_is_limit = w_at_top;
            if (!w_at_top) begin
                w_next_ext = w_q_ext + (WIDTH+1)'(1);
            end else if (!SATURATE) begin
                w_next_ext = '0;
            end
        end else begin
            o_is_limit = w_at_bot;
            if (!w_at_bot) begin
                w_next_ext = w_q_ext - (WIDTH+1)'(1);
            end else if (!SATURATE) begin
                w_next_ext = MAX_EXT;
            end
        end
    end

    // Top bit is always zero once the limits are handled.
    assign w_unused_carry = w_next_ext[WIDTH];
    assign o_next_q       = w_next_ext[WIDTH-1:0];

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with configurable modulus, load, tc and wrap.
// Define MOD_UPDOWN_COUNTER_SATURATE_EN to saturate at the limits instead of wrapping.
module mod_updown_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULUS   = 16,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);
    import cnt_pkg::*;

`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

    if (WIDTH == 0) begin : g_err_width
        $error("mod_updown_counter: WIDTH must be >= 1");
    end
    if (MODULUS < 2) begin : g_err_mod_lo
        $error("mod_updown_counter: MODULUS must be >= 2");
    end
    if (min_width(MODULUS) > WIDTH) begin : g_err_mod_hi
        $error("mod_updown_counter: MODULUS must be <= 2**WIDTH");
    end
    if (RESET_VAL >= MODULUS) begin : g_err_rst
        $error("mod_updown_counter: RESET_VAL must be < MODULUS");
    end

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_step_q;
    logic [WIDTH-1:0] w_load_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_wrap_nxt;
    logic             w_is_limit;

    mod_step #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_step (
        .i_q        (r_q),
        .i_up_dn    (up_dn),
        .o_next_q   (w_step_q),
        .o_is_limit (w_is_limit)
    );

    // Out-of-range load values clamp to the top of the count range.
    assign w_load_q = ({1'b0, load_val} > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : load_val;

    // Priority: load over count over hold.
    always_comb begin
        w_q_nxt    = r_q;
        w_wrap_nxt = 1'b0;
        if (load) begin
            w_q_nxt = w_load_q;
        end else if (en) begin
            w_q_nxt    = w_step_q;
            w_wrap_nxt = w_is_limit & ~SATURATE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q    <= WIDTH'(RESET_VAL);
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;
    assign tc   = en & w_is_limit;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: MODULUS=10 and MODULUS=16 counters against an arithmetic model.
`timescale 1ns/1ps
module tb_mod_updown_counter;

`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] q_a;
    logic [3:0] q_b;
    logic       tc_a;
    logic       tc_b;
    logic       wrap_a;
    logic       wrap_b;

    int n_checks = 0;
    int n_errors = 0;

    int mods [2] = '{10, 16};
    int mq   [2];
    int mw   [2];

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_dut_a (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q_a), .tc(tc_a), .wrap(wrap_a)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_dut_b (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q_b), .tc(tc_b), .wrap(wrap_b)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: modular arithmetic on plain integers.
    function automatic int model_next(input int qv, input int m);
        int r;
        if (load) begin
            r = (int'(load_val) > m - 1) ? m - 1 : int'(load_val);
        end else if (!en) begin
            r = qv;
        end else if (up_dn) begin
            r = (SAT && qv == m - 1) ? qv : (qv + 1) % m;
        end else begin
            r = (SAT && qv == 0) ? qv : (qv + m - 1) % m;
        end
        return r;
    endfunction

    function automatic int model_wrap(input int qv, input int m);
        bit hit;
        hit = up_dn ? (qv == m - 1) : (qv == 0);
        return (!SAT && !load && en && hit) ? 1 : 0;
    endfunction

    function automatic int model_tc(input int qv, input int m);
        return (en && (up_dn ? (qv == m - 1) : (qv == 0))) ? 1 : 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mq[k] <= 0;
                mw[k] <= 0;
            end else begin
                mq[k] <= model_next(mq[k], mods[k]);
                mw[k] <= model_wrap(mq[k], mods[k]);
            end
        end
    end

    // Every-cycle comparison away from the active edge.
    always @(negedge clk) begin
        check("q_a",    int'(q_a),    mq[0]);
        check("wrap_a", int'(wrap_a), mw[0]);
        check("tc_a",   int'(tc_a),   model_tc(mq[0], 10));
        check("q_b",    int'(q_b),    mq[1]);
        check("wrap_b", int'(wrap_b), mw[1]);
        check("tc_b",   int'(tc_b),   model_tc(mq[1], 16));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] v);
        load     = 1'b1;
        load_val = v;
        cyc();
        load     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = '0;
        #3;
        check("rst_q",    int'(q_a),    0);
        check("rst_wrap", int'(wrap_a), 0);
        #12 reset = 1'b0;

        // Up count 1..9 then the modulus edge.
        for (int i = 1; i <= 9; i++) begin
            cyc();
            check("up_q", int'(q_a), i);
        end
        check("up_tc9", int'(tc_a), 1);
        cyc();
        check("up_top_q",   int'(q_a),    SAT ? 9 : 0);
        check("up_wrap",    int'(wrap_a), SAT ? 0 : 1);
        check("up_b_q",     int'(q_b),    10);
        cyc();
        check("up_wrap_off", int'(wrap_a), 0);

        // Down count from 0.
        do_load(4'd0);
        check("ld0_wrap", int'(wrap_a), 0);
        up_dn = 1'b0;
        #1 check("dn_tc0", int'(tc_a), 1);
        cyc();
        check("dn_q9",    int'(q_a),    SAT ? 0 : 9);
        check("dn_wrap",  int'(wrap_a), SAT ? 0 : 1);
        check("dn_tc9",   int'(tc_a),   SAT ? 1 : 0);
        cyc();
        check("dn_q8",    int'(q_a),    SAT ? 0 : 8);
        check("dn_wrap2", int'(wrap_a), 0);

        // Loads, including the clamp.
        do_load(4'd7);
        check("ld7_q",    int'(q_a),    7);
        check("ld7_wrap", int'(wrap_a), 0);
        do_load(4'd12);
        check("ld12_q",   int'(q_a),    9);
        check("ld12_qb",  int'(q_b),    12);
        check("ld12_wrap", int'(wrap_a), 0);

        // Enable gating.
        do_load(4'd4);
        en = 1'b0; up_dn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("hold_q",  int'(q_a),  4);
            check("hold_tc", int'(tc_a), 0);
        end

        // Asynchronous reset mid-cycle.
        en = 1'b1;
        do_load(4'd6);
        check("pre_rst_q", int'(q_a), 6);
        #2 reset = 1'b1;
        #1 check("async_rst_q", int'(q_a), 0);
        #1 reset = 1'b0;

        // MODULUS=16 wrap from 15, and saturation points.
        up_dn = 1'b1;
        do_load(4'd15);
        check("b_q15", int'(q_b), 15);
        cyc();
        check("b_wrap_q",  int'(q_b),    SAT ? 15 : 0);
        check("b_wrap",    int'(wrap_b), SAT ? 0 : 1);
        do_load(4'd8);
        cyc();
        check("sat_up_q9", int'(q_a), 9);
        cyc();
        check("sat_up_hold", int'(q_a),  SAT ? 9 : 0);
        check("sat_up_wrap", int'(wrap_a), SAT ? 0 : 1);
        do_load(4'd1);
        up_dn = 1'b0;
        cyc();
        check("sat_dn_q0", int'(q_a), 0);
        cyc();
        check("sat_dn_hold", int'(q_a), SAT ? 0 : 9);

        // Randomized phase, checked by the per-cycle compare process.
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = $urandom_range(0, 1) == 1;
            load     = ($urandom_range(0, 15) == 0);
            load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            cyc();
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
